// File: rtl/vga_sprite_bank_ram.sv
// Multi-sprite, optionally double-buffered sprite RAM: Avalon-MM CPU/CSR port,
// fixed-latency pixel read port, hardware fill engine and vblank-synchronised buffer swap.
module vga_sprite_bank_ram #(
  parameter int PIX_W         = 16,
  parameter int PIX_PER_WORD  = 2,
  parameter int SPRITE_PIXELS = 2048,
  parameter int NUM_SPRITES   = 4,
  parameter int DOUBLE_BUF    = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [$clog2(NUM_SPRITES)+$clog2(SPRITE_PIXELS/PIX_PER_WORD):0] avs_address,
  input  logic                                   avs_read,
  input  logic                                   avs_write,
  input  logic [PIX_W*PIX_PER_WORD/8-1:0]        avs_byteenable,
  input  logic [PIX_W*PIX_PER_WORD-1:0]          avs_writedata,
  output logic [PIX_W*PIX_PER_WORD-1:0]          avs_readdata,
  output logic                                   avs_waitrequest,
  input  logic                                   vblank,
  input  logic                                   pix_req,
  input  logic [$clog2(NUM_SPRITES)-1:0]         pix_sprite,
  input  logic [$clog2(SPRITE_PIXELS)-1:0]       pix_addr,
  output logic                                   pix_valid,
  output logic [PIX_W-1:0]                       pix_data,
  output logic                                   fill_done_irq,
  output logic                                   o_dbg_fill_state
);

  localparam int DW        = PIX_W * PIX_PER_WORD;
  localparam int NB        = DW / 8;
  localparam int WPS       = SPRITE_PIXELS / PIX_PER_WORD;
  localparam int SW        = $clog2(NUM_SPRITES);
  localparam int WW        = $clog2(WPS);
  localparam int PW        = $clog2(SPRITE_PIXELS);
  localparam int LW        = $clog2(PIX_PER_WORD);
  localparam int LWS       = (LW > 0) ? LW : 1;
  localparam int BB        = (DOUBLE_BUF != 0) ? 1 : 0;
  localparam int AW        = BB + SW + WW;
  localparam int MEM_WORDS = NUM_SPRITES * (BB + 1) * WPS;

  typedef enum logic {S_IDLE, S_FILL} fill_state_t;

  fill_state_t       r_state, w_state_nxt;
  logic              r_front_buf, r_swap_pending, r_fill_irq;
  logic [WW-1:0]     r_fill_cnt;
  logic [SW-1:0]     r_fill_spr, r_csr_sprite;
  logic [PIX_W-1:0]  r_fill_col, r_csr_color;
  logic [DW-1:0]     r_readdata;
  logic              r_pix_valid;
  logic [PIX_W-1:0]  r_pix_data;
  logic [DW-1:0]     r_mem [0:MEM_WORDS-1];

  logic              w_is_csr, w_fill_busy, w_waitreq, w_rd_acc, w_wr_acc, w_csr_wr;
  logic              w_fill_start, w_swap_req, w_back_buf, w_fill_last, w_do_swap;
  logic [1:0]        w_csr_reg;
  logic [SW-1:0]     w_mem_sprite;
  logic [WW-1:0]     w_mem_word;
  logic [AW-1:0]     w_cpu_idx, w_fill_idx, w_pix_idx;
  logic [DW-1:0]     w_csr_rdata, w_pix_word;
  logic [LWS-1:0]    w_lane;
  logic [PIX_W-1:0]  w_pix_lane;

  // Avalon: a strobe is accepted on a rising edge where avs_waitrequest is low;
  // read data appears on avs_readdata exactly one cycle after acceptance.
  assign w_is_csr     = avs_address[SW+WW];
  assign w_csr_reg    = avs_address[1:0];
  assign w_mem_sprite = avs_address[SW+WW-1:WW];
  assign w_mem_word   = avs_address[WW-1:0];
  assign w_fill_busy  = (r_state == S_FILL);
  assign w_waitreq    = w_fill_busy && !w_is_csr && (avs_read || avs_write);
  assign w_rd_acc     = avs_read && !w_waitreq;
  assign w_wr_acc     = avs_write && !w_waitreq;
  assign w_csr_wr     = avs_write && w_is_csr;
  assign w_fill_start = w_csr_wr && (w_csr_reg == 2'd0) && avs_writedata[0];
  assign w_swap_req   = w_csr_wr && (w_csr_reg == 2'd0) && avs_writedata[1] && (BB == 1);
  assign w_back_buf   = (BB == 1) ? ~r_front_buf : 1'b0;
  assign w_fill_last  = (r_fill_cnt == WW'(WPS - 1));
  assign w_do_swap    = vblank && r_swap_pending && !w_fill_busy;

  // The buffer bit drops out of the index when single-buffered.
  assign w_cpu_idx  = AW'({w_back_buf, w_mem_sprite, w_mem_word});
  assign w_fill_idx = AW'({w_back_buf, r_fill_spr, r_fill_cnt});
  assign w_pix_idx  = AW'({r_front_buf, pix_sprite, pix_addr[PW-1:LW]});
  assign w_pix_word = r_mem[w_pix_idx];
  assign w_lane     = (LW > 0) ? pix_addr[LWS-1:0] : '0;

  always_comb begin
    w_pix_lane = w_pix_word[PIX_W-1:0];
    for (int l = 0; l < PIX_PER_WORD; l++) begin
      if (w_lane == LWS'(l)) w_pix_lane = w_pix_word[l*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    w_csr_rdata = '0;
    case (w_csr_reg)
      2'd1:    w_csr_rdata[2:0]       = {r_swap_pending, r_front_buf, w_fill_busy};
      2'd2:    w_csr_rdata[SW-1:0]    = r_csr_sprite;
      2'd3:    w_csr_rdata[PIX_W-1:0] = r_csr_color;
      default: w_csr_rdata            = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fill_start) w_state_nxt = S_FILL;
      S_FILL:  if (w_fill_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_front_buf    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_fill_irq     <= 1'b0;
      r_fill_cnt     <= '0;
      r_fill_spr     <= '0;
      r_fill_col     <= '0;
      r_csr_sprite   <= '0;
      r_csr_color    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_irq <= w_fill_busy && w_fill_last;
      // Fill parameters are snapshotted so CSR updates mid-fill do not disturb it.
      if (w_fill_start && !w_fill_busy) begin
        r_fill_spr <= r_csr_sprite;
        r_fill_col <= r_csr_color;
        r_fill_cnt <= '0;
      end else if (w_fill_busy) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_csr_wr && (w_csr_reg == 2'd2)) r_csr_sprite <= avs_writedata[SW-1:0];
      if (w_csr_wr && (w_csr_reg == 2'd3)) r_csr_color  <= avs_writedata[PIX_W-1:0];
      if (w_do_swap) begin
        r_front_buf    <= ~r_front_buf;
        r_swap_pending <= 1'b0;
      end
      // A request landing on the same vblank is kept for the next one.
      if (w_swap_req) r_swap_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      if (w_rd_acc) r_readdata <= w_is_csr ? w_csr_rdata : r_mem[w_cpu_idx];
      r_pix_valid <= pix_req;
      if (pix_req) r_pix_data <= w_pix_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_busy) begin
      r_mem[w_fill_idx] <= {PIX_PER_WORD{r_fill_col}};
    end else if (w_wr_acc && !w_is_csr) begin
      for (int b = 0; b < NB; b++) begin
        if (avs_byteenable[b]) r_mem[w_cpu_idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  assign avs_readdata     = r_readdata;
  assign avs_waitrequest  = w_waitreq;
  assign pix_valid        = r_pix_valid;
  assign pix_data         = r_pix_data;
  assign fill_done_irq    = r_fill_irq;
  assign o_dbg_fill_state = r_state;

endmodule
